// File: rtl/alu_pkg.sv
// Shared types and constants for the bitwise ALU and its interrupt controller.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 8;
  localparam int unsigned ALU_OP_W   = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_A_AND  = 2'b00,
    OP_A_NAND = 2'b01,
    OP_A_OR   = 2'b10,
    OP_A_XOR  = 2'b11
  } operation_a;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_B_XNOR = 2'b00,
    OP_B_AND  = 2'b01,
    OP_B_NOR  = 2'b10,
    OP_B_OR   = 2'b11
  } operation_b;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_PEND = 1'b1
  } irq_state_t;

  localparam logic [ALU_DATA_W-1:0] TRIG_A_AND  = 8'hFF;
  localparam logic [ALU_DATA_W-1:0] TRIG_A_NAND = 8'h00;
  localparam logic [ALU_DATA_W-1:0] TRIG_A_OR   = 8'hF8;
  localparam logic [ALU_DATA_W-1:0] TRIG_A_XOR  = 8'h83;
  localparam logic [ALU_DATA_W-1:0] TRIG_B_XNOR = 8'hF1;
  localparam logic [ALU_DATA_W-1:0] TRIG_B_AND  = 8'hF4;
  localparam logic [ALU_DATA_W-1:0] TRIG_B_NOR  = 8'hF5;
  localparam logic [ALU_DATA_W-1:0] TRIG_B_OR   = 8'hFF;

  function automatic logic [ALU_DATA_W-1:0] trigger_a(input operation_a op);
    case (op)
      OP_A_AND:  trigger_a = TRIG_A_AND;
      OP_A_NAND: trigger_a = TRIG_A_NAND;
      OP_A_OR:   trigger_a = TRIG_A_OR;
      default:   trigger_a = TRIG_A_XOR;
    endcase
  endfunction

  function automatic logic [ALU_DATA_W-1:0] trigger_b(input operation_b op);
    case (op)
      OP_B_XNOR: trigger_b = TRIG_B_XNOR;
      OP_B_AND:  trigger_b = TRIG_B_AND;
      OP_B_NOR:  trigger_b = TRIG_B_NOR;
      default:   trigger_b = TRIG_B_OR;
    endcase
  endfunction

endpackage

// File: rtl/alu_irq_ctrl.sv
// Sticky interrupt controller: set by a result event, cleared by a sampled clear;
// an event in the same cycle as a clear keeps the interrupt pending.
module alu_irq_ctrl
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic irq_event,
  input  logic irq_clr,
  output logic alu_irq
);

  irq_state_t state_q, state_d;
  logic       irq_q, irq_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (irq_event) state_d = IRQ_PEND;
      end
      IRQ_PEND: begin
        if (irq_clr && !irq_event) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
    irq_d = (state_d == IRQ_PEND);
  end

  assign alu_irq = irq_q;

endmodule

// File: rtl/alu_core.sv
// Two-mode bitwise ALU with a registered result and a sticky trigger-value interrupt.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_enable,
  input  logic              alu_enable_a,
  input  logic              alu_enable_b,
  input  logic [1:0]        alu_op_a,
  input  logic [1:0]        alu_op_b,
  input  logic [DATA_W-1:0] alu_in_a,
  input  logic [DATA_W-1:0] alu_in_b,
  input  logic              alu_irq_clr,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_irq
);

  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] result_c;
  logic [DATA_W-1:0] trigger_c;
  logic              valid_c;
  logic              event_c;
  operation_a        op_a_c;
  operation_b        op_b_c;

  assign op_a_c = operation_a'(alu_op_a);
  assign op_b_c = operation_b'(alu_op_b);

  // Exactly one mode select must be high; both high is an ignored illegal cycle.
  assign valid_c = alu_enable && (alu_enable_a ^ alu_enable_b);

  always_comb begin
    result_c  = '0;
    trigger_c = '0;
    if (alu_enable_a) begin
      trigger_c = DATA_W'(trigger_a(op_a_c));
      case (op_a_c)
        OP_A_AND:  result_c = alu_in_a & alu_in_b;
        OP_A_NAND: result_c = ~(alu_in_a & alu_in_b);
        OP_A_OR:   result_c = alu_in_a | alu_in_b;
        default:   result_c = alu_in_a ^ alu_in_b;
      endcase
    end else begin
      trigger_c = DATA_W'(trigger_b(op_b_c));
      case (op_b_c)
        OP_B_XNOR: result_c = ~(alu_in_a ^ alu_in_b);
        OP_B_AND:  result_c = alu_in_a & alu_in_b;
        OP_B_NOR:  result_c = ~(alu_in_a | alu_in_b);
        default:   result_c = alu_in_a | alu_in_b;
      endcase
    end
  end

  assign event_c = valid_c && (result_c == trigger_c);

  always_comb begin
    out_d = out_q;
    if (valid_c) out_d = result_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign alu_out = out_q;

  alu_irq_ctrl u_irq_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_event (event_c),
    .irq_clr   (alu_irq_clr),
    .alu_irq   (alu_irq)
  );

endmodule
